// File: rtl/hamming_frame_encoder.sv
// rtl/hamming_frame_encoder.sv - serial Hamming(7,4) frame encoder with sync header, interleaver and double buffer
// Optional build macro: HAMMING_SECDED_EN selects Hamming(8,4) SECDED blocks (cw[7] = overall even parity).

module hamming_frame_encoder #(
    parameter int         NUM_BLOCKS = 8,
    parameter logic [7:0] SYNC_WORD  = 8'h7E,
    parameter int         INTERLEAVE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eof,
    output logic [15:0] frame_count
);

`ifdef HAMMING_SECDED_EN
    localparam int BLK_W = 8;
`else
    localparam int BLK_W = 7;
`endif
    localparam int DATA_W    = 4 * NUM_BLOCKS;
    localparam int PAYLOAD_W = BLK_W * NUM_BLOCKS;
    localparam int FRAME_W   = 8 + PAYLOAD_W;
    localparam int WR_W      = $clog2(DATA_W);
    localparam int RD_W      = $clog2(FRAME_W);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [DATA_W-1:0]    col_data;
    logic [WR_W-1:0]      wr_cnt;
    logic                 col_full;

    logic [FRAME_W-1:0]   tx_buf;
    logic [RD_W-1:0]      rd_cnt;
    logic [15:0]          frame_cnt;

    logic [PAYLOAD_W-1:0] payload;
    logic [FRAME_W-1:0]   frame_word;
    logic [3:0]           nib;
    logic [BLK_W-1:0]     cw;

    logic                 accept_in;
    logic                 tx_adv;
    logic                 last_tx;
    logic                 load;

    // The collector is the input half of the double buffer: it refills while tx_buf drains
    assign in_ready    = ~col_full;
    assign accept_in   = in_valid & in_ready;
    assign tx_adv      = (state == SEND) & out_ready;
    assign last_tx     = tx_adv & (rd_cnt == RD_W'(FRAME_W - 1));
    // Loading on the last accepted bit gives back-to-back frames with no idle cycle
    assign load        = col_full & ((state == IDLE) | last_tx);
    assign frame_count = frame_cnt;

    // Encode every nibble of the collected word and place its codeword bits in the payload
    always_comb begin
        payload = '0;
        nib     = '0;
        cw      = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            nib     = col_data[4*i +: 4];
            cw      = '0;
            cw[6:0] = {nib[3], nib[2], nib[1],
                       nib[1] ^ nib[2] ^ nib[3],
                       nib[0],
                       nib[0] ^ nib[2] ^ nib[3],
                       nib[0] ^ nib[1] ^ nib[3]};
`ifdef HAMMING_SECDED_EN
            cw[7]   = ^cw[6:0];
`endif
            for (int j = 0; j < BLK_W; j++) begin
                if (INTERLEAVE != 0) begin
                    payload[j*NUM_BLOCKS + i] = cw[j];
                end else begin
                    payload[BLK_W*i + j] = cw[j];
                end
            end
        end
        frame_word = {SYNC_WORD, payload};
    end

    // Input collector: shift bits in MSB first until DATA_W bits are held, then wait for a load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_data <= '0;
            wr_cnt   <= '0;
            col_full <= 1'b0;
        end else if (load) begin
            col_data <= '0;
            wr_cnt   <= '0;
            col_full <= 1'b0;
        end else if (accept_in) begin
            col_data <= {col_data[DATA_W-2:0], in_data};
            if (wr_cnt == WR_W'(DATA_W - 1)) begin
                wr_cnt   <= '0;
                col_full <= 1'b1;
            end else begin
                wr_cnt <= wr_cnt + WR_W'(1);
            end
        end
    end

    // Transmitter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Transmitter next-state: stay in SEND across frames when the next one is already waiting
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (last_tx) begin
                    state_nxt = load ? SEND : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Transmitter outputs decode from state and registered data only, so they hold while stalled
    always_comb begin
        out_valid = 1'b0;
        out_data  = 1'b0;
        out_sof   = 1'b0;
        out_eof   = 1'b0;
        if (state == SEND) begin
            out_valid = 1'b1;
            out_data  = tx_buf[FRAME_W-1];
            out_sof   = (rd_cnt == '0);
            out_eof   = (rd_cnt == RD_W'(FRAME_W - 1));
        end
    end

    // Transmit buffer shifts MSB out on each accepted bit; frame counter wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_buf    <= '0;
            rd_cnt    <= '0;
            frame_cnt <= '0;
        end else begin
            if (load) begin
                tx_buf <= frame_word;
                rd_cnt <= '0;
            end else if (tx_adv) begin
                tx_buf <= {tx_buf[FRAME_W-2:0], 1'b0};
                rd_cnt <= last_tx ? '0 : rd_cnt + RD_W'(1);
            end
            if (last_tx) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_frame_encoder.sv
// tb/tb_hamming_frame_encoder.sv - directed self-checking bench for hamming_frame_encoder

module tb_hamming_frame_encoder;

`ifdef HAMMING_SECDED_EN
    localparam int BW = 8;
`else
    localparam int BW = 7;
`endif
    localparam int FW0 = 8 + BW;
    localparam int FW1 = 8 + 2 * BW;
    localparam int FW3 = 8 + 8 * BW;

`ifdef HAMMING_SECDED_EN
    localparam logic [FW0-1:0] EXP_1011   = {8'h7E, 8'b01010101};
    localparam logic [FW0-1:0] EXP_0110   = {8'h7E, 8'b00110011};
    localparam logic [FW1-1:0] EXP_F0_IL  = {8'h7E, 16'b1010101010101010};
    localparam logic [FW1-1:0] EXP_F0_SEQ = {8'h7E, 8'b11111111, 8'b00000000};
`else
    localparam logic [FW0-1:0] EXP_1011   = {8'h7E, 7'b1010101};
    localparam logic [FW0-1:0] EXP_0110   = {8'h7E, 7'b0110011};
    localparam logic [FW1-1:0] EXP_F0_IL  = {8'h7E, 14'b10101010101010};
    localparam logic [FW1-1:0] EXP_F0_SEQ = {8'h7E, 7'b1111111, 7'b0000000};
`endif

    logic        clk;
    logic        rst_n;
    logic [3:0]  idat, ival, ordy;
    logic [3:0]  ird, odat, oval, osof, oeof;
    logic [15:0] fc [4];

    int checks = 0;
    int errors = 0;
    int run3   = 0;
    int viol3  = 0;

    hamming_frame_encoder #(.NUM_BLOCKS(1), .SYNC_WORD(8'h7E), .INTERLEAVE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(idat[0]), .in_valid(ival[0]), .in_ready(ird[0]),
        .out_data(odat[0]), .out_valid(oval[0]), .out_ready(ordy[0]), .out_sof(osof[0]),
        .out_eof(oeof[0]), .frame_count(fc[0]));
    hamming_frame_encoder #(.NUM_BLOCKS(2), .SYNC_WORD(8'h7E), .INTERLEAVE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(idat[1]), .in_valid(ival[1]), .in_ready(ird[1]),
        .out_data(odat[1]), .out_valid(oval[1]), .out_ready(ordy[1]), .out_sof(osof[1]),
        .out_eof(oeof[1]), .frame_count(fc[1]));
    hamming_frame_encoder #(.NUM_BLOCKS(2), .SYNC_WORD(8'h7E), .INTERLEAVE(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_data(idat[2]), .in_valid(ival[2]), .in_ready(ird[2]),
        .out_data(odat[2]), .out_valid(oval[2]), .out_ready(ordy[2]), .out_sof(osof[2]),
        .out_eof(oeof[2]), .frame_count(fc[2]));
    hamming_frame_encoder #(.NUM_BLOCKS(8), .SYNC_WORD(8'h7E), .INTERLEAVE(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(idat[3]), .in_valid(ival[3]), .in_ready(ird[3]),
        .out_data(odat[3]), .out_valid(oval[3]), .out_ready(ordy[3]), .out_sof(osof[3]),
        .out_eof(oeof[3]), .frame_count(fc[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in_ready may be low with the tx idle for one cycle only (the load cycle)
    always @(negedge clk) begin
        if (!rst_n) begin
            run3 <= 0;
        end else if (!ird[3] && !oval[3]) begin
            run3 <= run3 + 1;
            if (run3 >= 1) viol3 <= viol3 + 1;
        end else begin
            run3 <= 0;
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] frame_of(input logic [31:0] d);
        logic [7:0]   cw [8];
        logic [255:0] pay;
        logic [3:0]   n;
        for (int i = 0; i < 8; i++) begin
            n = d[4*i +: 4];
            cw[i][0] = n[0] ^ n[1] ^ n[3];
            cw[i][1] = n[0] ^ n[2] ^ n[3];
            cw[i][2] = n[0];
            cw[i][3] = n[1] ^ n[2] ^ n[3];
            cw[i][4] = n[1];
            cw[i][5] = n[2];
            cw[i][6] = n[3];
`ifdef HAMMING_SECDED_EN
            cw[i][7] = ^cw[i][6:0];
`else
            cw[i][7] = 1'b0;
`endif
        end
        pay = '0;
        for (int p = 0; p < 8 * BW; p++) pay[p] = cw[p % 8][p / 8];
        return (256'h7E << (8 * BW)) | pay;
    endfunction

    task automatic push(input int k, input logic [127:0] data, input int n);
        int  i     = n - 1;
        int  guard = 0;
        logic acc;
        @(negedge clk);
        while (i >= 0 && guard < 20000) begin
            idat[k] = data[i];
            ival[k] = 1'b1;
            acc     = ird[k];
            @(negedge clk);
            if (acc) i--;
            guard++;
        end
        ival[k] = 1'b0;
        idat[k] = 1'b0;
    endtask

    task automatic pull(input int k, input int n, input int fw, input bit rnd,
                        output logic [255:0] bits, output int got, output int fr_err,
                        output int hold_err, output int gaps);
        int   guard   = 0;
        bit   started = 0;
        bit   stalled = 0;
        logic pd, ps, pe;
        bits = '0; got = 0; fr_err = 0; hold_err = 0; gaps = 0;
        pd = 1'b0; ps = 1'b0; pe = 1'b0;
        while (got < n && guard < 20000) begin
            ordy[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (oval[k]) begin
                started = 1;
                if (stalled && (odat[k] !== pd || osof[k] !== ps || oeof[k] !== pe)) hold_err++;
                if (osof[k] !== (got % fw == 0)) fr_err++;
                if (oeof[k] !== (got % fw == fw - 1)) fr_err++;
                if (ordy[k]) begin
                    bits    = {bits[254:0], odat[k]};
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    pd = odat[k]; ps = osof[k]; pe = oeof[k];
                end
            end else if (started) begin
                gaps++;
            end
            @(negedge clk);
            guard++;
        end
        ordy[k] = 1'b0;
    endtask

    logic [255:0] b0, b1, exp;
    int           g0, g1, e0, e1, h0, h1, q0, q1;
    logic [31:0]  dv [3];

    initial begin
        rst_n = 1'b0;
        idat = '0; ival = '0; ordy = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 256'(ird), 256'(4'hF));
        check("rst_out_valid", 256'(oval), 256'(0));
        check("rst_out_flags", 256'({odat, osof, oeof}), 256'(0));
        check("rst_frame_count", 256'({fc[0], fc[3]}), 256'(0));
        rst_n = 1'b1;

        // single block 1011, latency and framing
        push(0, 128'b1011, 4);
        check("lat_not_yet", 256'(oval[0]), 256'(0));
        @(negedge clk);
        check("lat_valid_sof", 256'({oval[0], osof[0]}), 256'(2'b11));
        pull(0, FW0, FW0, 0, b0, g0, e0, h0, q0);
        check("nb1_frame", b0, 256'(EXP_1011));
        check("nb1_sof_eof", 256'(e0), 256'(0));
        check("nb1_count", 256'(fc[0]), 256'(1));
        check("nb1_idle_after", 256'(oval[0]), 256'(0));

        // asynchronous reset mid-frame with a partial input collected
        push(0, 128'b1011, 4);
        @(negedge clk);
        ordy[0] = 1'b1;
        repeat (3) @(negedge clk);
        ordy[0] = 1'b0;
        push(0, 128'b11, 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 256'(oval[0]), 256'(0));
        check("rst_async_state", 256'({ird[0], fc[0]}), 256'({1'b1, 16'd0}));
        @(negedge clk);
        rst_n = 1'b1;
        push(0, 128'b0110, 4);
        pull(0, FW0, FW0, 0, b0, g0, e0, h0, q0);
        check("post_rst_frame", b0, 256'(EXP_0110));
        check("post_rst_count", 256'(fc[0]), 256'(1));

        // two blocks 8'hF0, interleaved and in order
        fork
            push(1, 128'hF0, 8);
            push(2, 128'hF0, 8);
        join
        fork
            pull(1, FW1, FW1, 0, b0, g0, e0, h0, q0);
            pull(2, FW1, FW1, 0, b1, g1, e1, h1, q1);
        join
        check("nb2_interleave", b0, 256'(EXP_F0_IL));
        check("nb2_in_order", b1, 256'(EXP_F0_SEQ));
        check("nb2_sof_eof", 256'(e0 + e1), 256'(0));

        // eight blocks, three frames, continuous source and sink
        dv[0] = 32'h1234_5678; dv[1] = 32'hDEAD_BEEF; dv[2] = 32'h0F1E_2D3C;
        fork
            push(3, {32'h0, dv[0], dv[1], dv[2]}, 96);
            pull(3, 3 * FW3, FW3, 0, b0, g0, e0, h0, q0);
        join
        exp = '0;
        for (int f = 0; f < 3; f++) exp = (exp << FW3) | frame_of(dv[f]);
        check("nb8_stream", b0, exp);
        check("nb8_len", 256'(g0), 256'(3 * FW3));
        check("nb8_no_gap", 256'(q0), 256'(0));
        check("nb8_sof_eof", 256'(e0), 256'(0));
        check("nb8_count", 256'(fc[3]), 256'(3));

        // eight blocks, two frames, random backpressure
        dv[0] = $urandom; dv[1] = $urandom;
        fork
            push(3, {64'h0, dv[0], dv[1]}, 64);
            pull(3, 2 * FW3, FW3, 1, b0, g0, e0, h0, q0);
        join
        exp = (frame_of(dv[0]) << FW3) | frame_of(dv[1]);
        check("bp_stream", b0, exp);
        check("bp_len", 256'(g0), 256'(2 * FW3));
        check("bp_hold", 256'(h0), 256'(0));
        check("bp_sof_eof", 256'(e0), 256'(0));
        check("bp_count", 256'(fc[3]), 256'(5));
        check("bp_in_ready", 256'(viol3), 256'(0));

        // frame counter wrap
        @(negedge clk);
        force u_dut0.frame_cnt = 16'hFFFF;
        #1 release u_dut0.frame_cnt;
        check("wrap_preload", 256'(fc[0]), 256'(16'hFFFF));
        push(0, 128'b1011, 4);
        pull(0, FW0, FW0, 0, b0, g0, e0, h0, q0);
        check("wrap_frame", b0, 256'(EXP_1011));
        check("wrap_count", 256'(fc[0]), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

endmodule
